// File: rtl/interrupt_scheduler_pkg.sv
// Shared types and constants for the interrupt scheduler: mip bit layout,
// RISC-V interrupt priority order, privilege encodings and the FSM state enum.
package interrupt_scheduler_pkg;

    localparam int unsigned IRQ_W   = 12;
    localparam int unsigned IRQ_NUM = 6;

    localparam logic [3:0] IRQ_SSI = 4'd1;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_STI = 4'd5;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_SEI = 4'd9;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    // Only these mip positions carry interrupts; everything else is ignored.
    localparam logic [IRQ_W-1:0] IRQ_MASK = 12'hAAA;

    // Index 0 is the highest priority.
    localparam logic [3:0] IRQ_PRIO [IRQ_NUM] = '{IRQ_MEI, IRQ_MSI, IRQ_MTI,
                                                  IRQ_SEI, IRQ_SSI, IRQ_STI};

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_REQUEST,
        ST_COOLDOWN
    } interrupt_sched_state_t;

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/interrupt_scheduler_if.sv
// Request/accept handshake between the interrupt scheduler and the
// global-control unit.
interface interrupt_scheduler_if;
    logic       interrupt_pending;
    logic [3:0] interrupt_code;
    logic       interrupt_to_s;
    logic       interrupt_taken;

    modport master (
        output interrupt_pending,
        output interrupt_code,
        output interrupt_to_s,
        input  interrupt_taken
    );

    modport slave (
        input  interrupt_pending,
        input  interrupt_code,
        input  interrupt_to_s,
        output interrupt_taken
    );
endinterface

// File: rtl/interrupt_scheduler_priority_encoder.sv
// Picks the highest-priority qualified interrupt and reports whether it is
// delegated to S-mode. Purely combinational.
module interrupt_priority_encoder
    import interrupt_scheduler_pkg::*;
(
    input  logic [IRQ_W-1:0] qual,
    input  logic [IRQ_W-1:0] deleg,
    output logic             eligible,
    output logic [3:0]       code,
    output logic             to_s
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        code = '0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (qual[IRQ_PRIO[i]]) begin
                code = IRQ_PRIO[i];
            end
        end
    end

    assign eligible = |(qual & IRQ_MASK);
    assign to_s     = eligible & deleg[code];

endmodule

// File: rtl/interrupt_scheduler.sv
// Qualifies pending interrupts against enables, delegation and privilege,
// then paces the winner through hold-off/request/cooldown toward gc_unit.
module interrupt_scheduler
    import interrupt_scheduler_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES  = 2,
    parameter int unsigned COOLDOWN_CYCLES = 1,
    parameter bit          INCLUDE_S_MODE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] mip,
    input  logic [IRQ_W-1:0] mie,
    input  logic [IRQ_W-1:0] mideleg,
    input  logic             mstatus_mie,
    input  logic             mstatus_sie,
    input  logic [1:0]       privilege,
    input  logic             block,
    interrupt_scheduler_if.master gc
);

    localparam int unsigned CNT_W = cnt_width(HOLDOFF_CYCLES, COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((HOLDOFF_CYCLES  > 0) ? HOLDOFF_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] COOL_LAST =
        CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    interrupt_sched_state_t state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q;
    logic [3:0]             code_q;
    logic                   to_s_q;

    logic [IRQ_W-1:0] deleg_eff;
    logic [IRQ_W-1:0] qual;
    logic             mach_ok;
    logic             deleg_ok;
    logic             eligible;
    logic [3:0]       win_code;
    logic             win_to_s;
    logic             go;

    assign deleg_eff = INCLUDE_S_MODE ? (mideleg & IRQ_MASK) : '0;

    // M-level traps are masked only while running in M with MIE clear;
    // S-level traps never preempt M and need SIE while in S.
    assign mach_ok  = (privilege != PRIV_M) | mstatus_mie;
    assign deleg_ok = (privilege == PRIV_U) | ((privilege == PRIV_S) & mstatus_sie);

    assign qual = mip & mie & ((deleg_eff & {IRQ_W{deleg_ok}}) |
                               (~deleg_eff & {IRQ_W{mach_ok}}));

    interrupt_priority_encoder u_prio (
        .qual     (qual),
        .deleg    (deleg_eff),
        .eligible (eligible),
        .code     (win_code),
        .to_s     (win_to_s)
    );

    assign go = eligible & ~block;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d = (HOLDOFF_CYCLES == 0) ? ST_REQUEST : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (!go) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REQUEST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REQUEST: begin
                // Acceptance wins over a simultaneous withdrawal or block.
                if (gc.interrupt_taken) begin
                    state_d = (COOLDOWN_CYCLES == 0) ? ST_IDLE : ST_COOLDOWN;
                    cnt_d   = '0;
                end else if (!go) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            code_q    <= '0;
            to_s_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= (state_d == ST_REQUEST);
            if (state_d == ST_REQUEST) begin
                code_q <= win_code;
                to_s_q <= win_to_s;
            end
        end
    end

    assign gc.interrupt_pending = pending_q;
    assign gc.interrupt_code    = code_q;
    assign gc.interrupt_to_s    = to_s_q;

    taken_without_request: assert property (
        @(posedge clk) disable iff (rst) gc.interrupt_taken |-> gc.interrupt_pending
    );

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler: qualification table, timing
// corner sequences and randomized traffic against a cycle-count reference model.
module tb_interrupt_scheduler;

    localparam int HOLDOFF  = 2;
    localparam int COOLDOWN = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mip = '0;
    logic [11:0] mie = '0;
    logic [11:0] mideleg = '0;
    logic        mstatus_mie = 1'b0;
    logic        mstatus_sie = 1'b0;
    logic [1:0]  privilege = 2'd3;
    logic        block = 1'b0;

    interrupt_scheduler_if gc_if ();

    interrupt_scheduler #(
        .HOLDOFF_CYCLES  (HOLDOFF),
        .COOLDOWN_CYCLES (COOLDOWN),
        .INCLUDE_S_MODE  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mip         (mip),
        .mie         (mie),
        .mideleg     (mideleg),
        .mstatus_mie (mstatus_mie),
        .mstatus_sie (mstatus_sie),
        .privilege   (privilege),
        .block       (block),
        .gc          (gc_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Counts consecutive cycles the request condition held; requests once the
    // count exceeds the hold-off length; after a take, idles for the cooldown.
    bit         m_req;
    int         m_run;
    int         m_cool;
    logic [3:0] m_code;
    bit         m_to_s;

    function automatic void ref_winner(output bit ok, output logic [3:0] code, output bit to_s);
        int order [6] = '{11, 3, 7, 9, 1, 5};
        ok = 1'b0;
        code = '0;
        to_s = 1'b0;
        foreach (order[k]) begin
            int b;
            bit dg;
            bit el;
            b = order[k];
            dg = mideleg[b];
            if (!ok && mip[b] && mie[b]) begin
                if (dg) el = (privilege == 2'd0) || (privilege == 2'd1 && mstatus_sie);
                else    el = (privilege != 2'd3) || mstatus_mie;
                if (el) begin
                    ok = 1'b1;
                    code = 4'(b);
                    to_s = dg;
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_req = 0; m_run = 0; m_cool = 0; m_code = '0; m_to_s = 0;
    endtask

    task automatic model_step();
        bit ok;
        logic [3:0] wc;
        bit ws;
        ref_winner(ok, wc, ws);
        ok = ok && !block;
        if (m_req) begin
            if (gc_if.interrupt_taken) begin
                m_req = 0; m_run = 0; m_cool = COOLDOWN;
            end else if (!ok) begin
                m_req = 0; m_run = 0;
            end else begin
                m_code = wc; m_to_s = ws;
            end
        end else if (m_cool > 0) begin
            m_cool--;
            m_run = 0;
        end else if (ok) begin
            m_run++;
            if (m_run > HOLDOFF) begin
                m_req = 1; m_run = 0; m_code = wc; m_to_s = ws;
            end
        end else begin
            m_run = 0;
        end
    endtask

    // One clock: advance the model on the inputs the DUT is about to sample,
    // then compare #1 after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_pending", 32'(gc_if.interrupt_pending), 32'(m_req));
        check("model_code",    32'(gc_if.interrupt_code),    32'(m_code));
        check("model_to_s",    32'(gc_if.interrupt_to_s),    32'(m_to_s));
    endtask

    task automatic do_reset();
        gc_if.interrupt_taken = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_pending", 32'(gc_if.interrupt_pending), 0);
        check("reset_code",    32'(gc_if.interrupt_code),    0);
        check("reset_to_s",    32'(gc_if.interrupt_to_s),    0);
        rst = 1'b0;
    endtask

    task automatic set_in(input logic [11:0] p, input logic [11:0] e, input logic [11:0] d,
                          input logic mm, input logic sm, input logic [1:0] pr);
        mip = p; mie = e; mideleg = d; mstatus_mie = mm; mstatus_sie = sm; privilege = pr;
    endtask

    typedef struct packed {
        logic [11:0] mip;
        logic [11:0] mie;
        logic [11:0] mideleg;
        logic        m_mie;
        logic        s_mie;
        logic [1:0]  priv;
        logic        exp_pend;
        logic [3:0]  exp_code;
        logic        exp_to_s;
    } vec_t;

    vec_t vecs [16];

    initial begin
        gc_if.interrupt_taken = 1'b0;

        vecs[0]  = '{12'h080, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3, 1'b1, 4'd7,  1'b0};
        vecs[1]  = '{12'h880, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3, 1'b1, 4'd11, 1'b0};
        vecs[2]  = '{12'h080, 12'hAAA, 12'h000, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[3]  = '{12'h080, 12'hAAA, 12'h000, 1'b0, 1'b0, 2'd1, 1'b1, 4'd7,  1'b0};
        vecs[4]  = '{12'h200, 12'hAAA, 12'h200, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[5]  = '{12'h200, 12'hAAA, 12'h200, 1'b0, 1'b1, 2'd1, 1'b1, 4'd9,  1'b1};
        vecs[6]  = '{12'h200, 12'hAAA, 12'h200, 1'b1, 1'b0, 2'd1, 1'b0, 4'd0,  1'b0};
        vecs[7]  = '{12'h200, 12'hAAA, 12'h200, 1'b0, 1'b0, 2'd0, 1'b1, 4'd9,  1'b1};
        vecs[8]  = '{12'h080, 12'h000, 12'h000, 1'b1, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[9]  = '{12'h288, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3, 1'b1, 4'd3,  1'b0};
        vecs[10] = '{12'h022, 12'hAAA, 12'h022, 1'b0, 1'b1, 2'd1, 1'b1, 4'd1,  1'b1};
        vecs[11] = '{12'h280, 12'hAAA, 12'h200, 1'b0, 1'b0, 2'd1, 1'b1, 4'd7,  1'b0};
        vecs[12] = '{12'h880, 12'hAAA, 12'h800, 1'b0, 1'b1, 2'd1, 1'b1, 4'd11, 1'b1};
        vecs[13] = '{12'h401, 12'hFFF, 12'h000, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[14] = '{12'h0A0, 12'hAAA, 12'h020, 1'b1, 1'b1, 2'd3, 1'b1, 4'd7,  1'b0};
        vecs[15] = '{12'h008, 12'hAAA, 12'h008, 1'b1, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};

        // Qualification / priority table: each vector starts from reset and
        // is held for the full hold-off window.
        foreach (vecs[v]) begin
            do_reset();
            set_in(vecs[v].mip, vecs[v].mie, vecs[v].mideleg,
                   vecs[v].m_mie, vecs[v].s_mie, vecs[v].priv);
            repeat (HOLDOFF + 1) tick();
            check($sformatf("vec%0d_pending", v), 32'(gc_if.interrupt_pending), 32'(vecs[v].exp_pend));
            check($sformatf("vec%0d_code", v),    32'(gc_if.interrupt_code),    32'(vecs[v].exp_code));
            check($sformatf("vec%0d_to_s", v),    32'(gc_if.interrupt_to_s),    32'(vecs[v].exp_to_s));
        end

        // MTI: request 3 cycles after mip, take, one cooldown cycle.
        do_reset();
        set_in(12'h080, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3);
        tick(); check("mti_c1", 32'(gc_if.interrupt_pending), 0);
        tick(); check("mti_c2", 32'(gc_if.interrupt_pending), 0);
        tick(); check("mti_c3", 32'(gc_if.interrupt_pending), 1);
        check("mti_code", 32'(gc_if.interrupt_code), 7);
        gc_if.interrupt_taken = 1'b1;
        tick(); check("mti_taken_drop", 32'(gc_if.interrupt_pending), 0);
        gc_if.interrupt_taken = 1'b0;
        tick(); check("mti_cool", 32'(gc_if.interrupt_pending), 0);
        tick(); tick();
        check("mti_rereq_early", 32'(gc_if.interrupt_pending), 0);
        tick(); check("mti_rereq", 32'(gc_if.interrupt_pending), 1);

        // MEI+MTI -> 11; drop MEI while requesting -> 7, still pending.
        do_reset();
        set_in(12'h880, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3);
        repeat (3) tick();
        check("mei_code", 32'(gc_if.interrupt_code), 11);
        mip = 12'h080;
        tick();
        check("mei_drop_code", 32'(gc_if.interrupt_code), 7);
        check("mei_drop_pend", 32'(gc_if.interrupt_pending), 1);

        // block during hold-off aborts; release restarts the full window.
        do_reset();
        set_in(12'h080, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3);
        tick();
        block = 1'b1;
        tick(); tick();
        check("block_hold", 32'(gc_if.interrupt_pending), 0);
        block = 1'b0;
        tick(); tick();
        check("block_restart_early", 32'(gc_if.interrupt_pending), 0);
        tick();
        check("block_restart", 32'(gc_if.interrupt_pending), 1);

        // Taken together with withdrawal still enters cooldown.
        do_reset();
        set_in(12'h080, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3);
        repeat (3) tick();
        gc_if.interrupt_taken = 1'b1;
        mip = 12'h000;
        tick();
        gc_if.interrupt_taken = 1'b0;
        mip = 12'h080;
        tick(); tick(); tick();
        check("taken_wd_cool", 32'(gc_if.interrupt_pending), 0);
        tick();
        check("taken_wd_rereq", 32'(gc_if.interrupt_pending), 1);

        // Asynchronous reset during REQUEST clears pending before any edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pend", 32'(gc_if.interrupt_pending), 0);
        check("async_rst_code", 32'(gc_if.interrupt_code), 0);
        do_reset();

        // MSI pulse shorter than the hold-off window never requests.
        set_in(12'h008, 12'hAAA, 12'h000, 1'b1, 1'b0, 2'd3);
        tick(); tick();
        mip = 12'h000;
        repeat (4) begin
            tick();
            check("msi_pulse", 32'(gc_if.interrupt_pending), 0);
        end

        // Randomized traffic against the model.
        do_reset();
        set_in(12'h000, 12'hAAA, 12'h000, 1'b1, 1'b1, 2'd3);
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                mie = 12'(($urandom % 4 == 0) ? $urandom : 32'hAAA);
                mideleg = 12'($urandom);
            end
            if ($urandom % 8 == 0) mip = 12'($urandom);
            if ($urandom % 16 == 0) begin
                case ($urandom % 3)
                    0: privilege = 2'd0;
                    1: privilege = 2'd1;
                    default: privilege = 2'd3;
                endcase
                mstatus_mie = 1'($urandom);
                mstatus_sie = 1'($urandom);
            end
            block = ($urandom % 10 == 0);
            gc_if.interrupt_taken = m_req && ($urandom % 3 == 0);
            tick();
        end
        gc_if.interrupt_taken = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_scheduler.md
Name: interrupt_scheduler

Overview:
- Sequences asynchronous interrupt sources into the single interrupt_pending/interrupt_taken handshake consumed by the global-control unit.
- Qualifies mip against mie, global enables, delegation and current privilege, then selects the winner by RISC-V priority.
- Enforces a hold-off window before requesting and a cooldown after a take.
- Sits between the CSR unit (mip/mie/mstatus/mideleg/privilege) and gc_unit.

Parameters:
- HOLDOFF_CYCLES, 2, cycles an eligible interrupt must persist, unblocked, before interrupt_pending asserts (0 = request next cycle).
- COOLDOWN_CYCLES, 1, cycles after interrupt_taken during which no new request is raised (0 = none).
- INCLUDE_S_MODE, 1, enables delegation/S-level interrupts; when 0, mideleg is treated as all-zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mip  in  12  pending bits (mip layout: 1 SSI, 3 MSI, 5 STI, 7 MTI, 9 SEI, 11 MEI; others ignored).
- mie  in  12  enable bits, same layout.
- mideleg  in  12  delegation bits, same layout.
- mstatus_mie  in  1  M global enable.
- mstatus_sie  in  1  S global enable.
- privilege  in  2  current privilege (0 U, 1 S, 3 M).
- block  in  1  suppress new requests (ifence/ret in progress, debug).
- interrupt_taken  in  1  gc accepted the request this cycle.
- interrupt_pending  out  1  registered request to gc.
- interrupt_code  out  4  registered cause of the current request.
- interrupt_to_s  out  1  registered; 1 = the winner traps to S.

Behaviour:
- Reset (async): state IDLE, counter 0, interrupt_pending 0, interrupt_code 0, interrupt_to_s 0. Assertion mid-operation aborts immediately; no request survives.
- Per-bit candidate: mip[i] & mie[i].
- Non-delegated bit is eligible iff privilege != M or mstatus_mie.
- Delegated bit is eligible iff privilege == U, or (privilege == S & mstatus_sie); never eligible at M.
- Priority: MEI > MSI > MTI > SEI > SSI > STI. "eligible" = any bit qualifies; winner code = bit index.
- Selection is combinational; all outputs are registered from next_state.
- States:
  - IDLE: on eligible & ~block, go to HOLDOFF, counter = 0; go directly to REQUEST if HOLDOFF_CYCLES == 0.
  - HOLDOFF: on ~eligible | block, return to IDLE. Otherwise counter++; at counter == HOLDOFF_CYCLES-1, go to REQUEST. Winner identity may change during HOLDOFF without restarting the count.
  - REQUEST: interrupt_pending = 1.
    - interrupt_taken: go to COOLDOWN. Taken has priority over withdrawal and block in the same cycle.
    - Else ~eligible | block: go to IDLE (withdraw); interrupt_pending drops next cycle.
    - Else stay; code/to_s re-evaluated every cycle, so a higher-priority arrival replaces the code.
  - COOLDOWN: interrupt_pending = 0. Counter counts COOLDOWN_CYCLES, then IDLE. If COOLDOWN_CYCLES == 0, REQUEST+taken goes straight to IDLE.
- interrupt_pending = registered (next_state == REQUEST).
- interrupt_code/interrupt_to_s load the winner whenever next_state == REQUEST and hold otherwise. The values presented in the taken cycle are the cause gc uses.
- interrupt_taken while interrupt_pending == 0 is ignored; flagged by a simulation assertion.
- Counter width: $clog2(max(HOLDOFF_CYCLES, COOLDOWN_CYCLES)+1); no wrap is possible.

Decomposition:
- csr_types gains:
  - interrupt bit-index constants (SSI=1, MSI=3, STI=5, MTI=7, SEI=9, MEI=11);
  - the priority order as a localparam array;
  - the interrupt_sched_state_t enum.
- Natural sub-module: interrupt_priority_encoder, purely combinational. It maps the qualified 12-bit vector plus mideleg to eligible, code and to_s.

Test Plan:
- MTI: mip[7]=mie[7]=1, mstatus_mie=1, priv=M, HOLDOFF=2 -> pending rises 3 cycles after mip, code=7, to_s=0. Taken -> pending 0 next cycle, no re-request for 1 cooldown cycle.
- MEI and MTI together -> code=11. Drop MEI while in REQUEST, not taken -> code becomes 7 next cycle, pending stays 1.
- SEI delegated (mideleg[9]=1): at priv=M -> no request; at priv=S with sie=1 -> request, code=9, to_s=1.
- block asserted during HOLDOFF -> IDLE, pending never rises. block deasserted -> full 2-cycle hold-off restarts.
- Taken and mip withdrawn in the same cycle -> COOLDOWN, not IDLE. rst pulsed during REQUEST -> pending 0 immediately (async).
- MSI pulse shorter than the hold-off window -> no request issued.
